uart_rx_oversampled: RTL and testbench

UART receiver FSM that consumes the oversampling enable from the RX sample-tick generator (16 ticks per bit period) and deserialises the asynchronous rx line into parallel bytes. Frame format is 1 start bit, DBIT data bits LSB first, no parity, and 1 stop bit of SB_TICK ticks. The block emits a one-cycle done pulse with the byte and a framing-error flag. It feeds the command/AES data path downstream.

---
 rtl/uart_rx_oversampled.sv | 152 +++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - oversampled UART receiver (16 ticks per bit)
//
// Deserialises the asynchronous rx line into DBIT-wide words using the 16x
// sample enable from the tick generator. Frame: 1 start bit, DBIT data bits
// LSB first, no parity, stop period of SB_TICK ticks.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   s_tick       sample enable, one tick per clk cycle it is high
//   rx           asynchronous serial line, idle high
//   dout         last received word, held until the next completed frame
//   rx_done_tick one-clk pulse when a frame completes
//   frame_err    stop bit sampled low; valid with rx_done_tick, then held
//   busy         registered, high whenever the FSM is not in IDLE
`timescale 1ns/1ps

module uart_rx_oversampled #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [4:0] SB_LAST = 5'(SB_TICK - 1);
  localparam logic [3:0] N_LAST  = 4'(DBIT - 1);

  state_t          state, state_next;
  logic            rx_meta, rx_s;
  logic [4:0]      s_cnt, s_cnt_next;
  logic [3:0]      n_cnt, n_cnt_next;
  logic [DBIT-1:0] shift, shift_next;
  logic            frame_end;
  logic [DBIT-1:0] dout_next;
  logic            done_next, ferr_next, busy_next;

  // Two-flop synchroniser; both flops reset to the idle level so a reset
  // never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      s_cnt        <= '0;
      n_cnt        <= '0;
      shift        <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      s_cnt        <= s_cnt_next;
      n_cnt        <= n_cnt_next;
      shift        <= shift_next;
      dout         <= dout_next;
      rx_done_tick <= done_next;
      frame_err    <= ferr_next;
      busy         <= busy_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    s_cnt_next = s_cnt;
    n_cnt_next = n_cnt;
    shift_next = shift;
    frame_end  = 1'b0;
    case (state)
      IDLE: begin
        // Start detection does not wait for a tick.
        if (!rx_s) begin
          state_next = START;
          s_cnt_next = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt == 5'd7) begin
            // Mid start bit: a high line here was only a glitch.
            if (!rx_s) begin
              state_next = DATA;
              s_cnt_next = '0;
              n_cnt_next = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_cnt_next = s_cnt + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt == 5'd15) begin
            s_cnt_next = '0;
            // LSB arrives first, so shifting in from the top leaves the
            // word aligned after DBIT bits.
            shift_next = {rx_s, shift[DBIT-1:1]};
            if (n_cnt == N_LAST) begin
              state_next = STOP;
            end else begin
              n_cnt_next = n_cnt + 4'd1;
            end
          end else begin
            s_cnt_next = s_cnt + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt == SB_LAST) begin
            state_next = IDLE;
            frame_end  = 1'b1;
          end else begin
            s_cnt_next = s_cnt + 5'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic; everything is registered so busy and the pulse line up
  // on the same clk.
  always_comb begin
    done_next = frame_end;
    dout_next = frame_end ? shift : dout;
    ferr_next = frame_end ? ~rx_s : frame_err;
    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - directed self-checking bench for uart_rx_oversampled
`timescale 1ns/1ps

module tb_uart_rx_oversampled;

  logic clk = 1'b0;
  logic reset, s_tick, rx, rx7;
  logic [7:0] dout;
  logic rx_done_tick, frame_err, busy;
  logic [6:0] dout7a, dout7b;
  logic done7a, done7b, ferr7a, ferr7b, busy7a, busy7b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ph = 0;

  int         q_cyc[$];
  logic [7:0] q_dout[$];
  logic       q_ferr[$];
  logic       q_busy[$];
  int         qa_cyc[$];
  logic [6:0] qa_dout[$];
  int         qb_cyc[$];
  logic [6:0] qb_dout[$];

  uart_rx_oversampled #(.DBIT(8), .SB_TICK(16)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx),
    .dout(dout), .rx_done_tick(rx_done_tick), .frame_err(frame_err), .busy(busy));

  uart_rx_oversampled #(.DBIT(7), .SB_TICK(16)) dut7a (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx7),
    .dout(dout7a), .rx_done_tick(done7a), .frame_err(ferr7a), .busy(busy7a));

  uart_rx_oversampled #(.DBIT(7), .SB_TICK(32)) dut7b (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx7),
    .dout(dout7b), .rx_done_tick(done7b), .frame_err(ferr7b), .busy(busy7b));

  initial forever #5 clk = ~clk;

  // s_tick: one clk high every 4 clk
  initial begin
    s_tick = 1'b0;
    forever begin
      @(posedge clk); #2;
      ph = (ph + 1) % 4;
      s_tick = (ph == 0);
    end
  end

  // Records every done pulse with its cycle number
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (rx_done_tick === 1'b1) begin
        q_cyc.push_back(cyc); q_dout.push_back(dout);
        q_ferr.push_back(frame_err); q_busy.push_back(busy);
      end
      if (done7a === 1'b1) begin qa_cyc.push_back(cyc); qa_dout.push_back(dout7a); end
      if (done7b === 1'b1) begin qb_cyc.push_back(cyc); qb_dout.push_back(dout7b); end
    end
  end

  task automatic set_line(input bit sel, input logic v);
    if (sel) rx7 = v; else rx = v;
  endtask

  task automatic drive_line(input bit sel, input logic v, input int n);
    @(negedge clk);
    set_line(sel, v);
    repeat (n - 1) @(negedge clk);
  endtask

  // Start edge placed on a negedge whose next posedge carries a tick, so
  // latencies are exact: done lands 609 clk after the edge for 8N1.
  task automatic align_start(input bit sel, output int s);
    do @(negedge clk); while (ph != 0);
    set_line(sel, 1'b0);
    s = cyc;
  endtask

  task automatic send_frame(input bit sel, input logic [8:0] data, input int nbits,
                            input logic stop_v, input int stop_n, input int idle_n,
                            output int s);
    align_start(sel, s);
    repeat (63) @(negedge clk);
    for (int i = 0; i < nbits; i++) drive_line(sel, data[i], 64);
    drive_line(sel, stop_v, stop_n);
    if (idle_n > 0) drive_line(sel, 1'b1, idle_n);
  endtask

  task automatic clear_q();
    q_cyc.delete(); q_dout.delete(); q_ferr.delete(); q_busy.delete();
    qa_cyc.delete(); qa_dout.delete(); qb_cyc.delete(); qb_dout.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; rx = 1'b1; rx7 = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (rx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", rx_done_tick); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %0b expected 0", frame_err); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
    checks++; if (dout7a !== 7'h00) begin errors++; $display("FAIL reset_dout7a: got %h expected 00", dout7a); end
    checks++; if (busy7b !== 1'b0) begin errors++; $display("FAIL reset_busy7b: got %0b expected 0", busy7b); end
  endtask

  task automatic test_basic();
    int s;
    clear_q();
    send_frame(1'b0, 9'h0A5, 8, 1'b1, 64, 64, s);
    checks++; if (q_cyc.size() != 1) begin errors++; $display("FAIL basic_pulses: got %0d expected 1", q_cyc.size()); end
    if (q_cyc.size() > 0) begin
      checks++; if (q_dout[0] !== 8'hA5) begin errors++; $display("FAIL basic_dout: got %h expected a5", q_dout[0]); end
      checks++; if (q_ferr[0] !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %0b expected 0", q_ferr[0]); end
      checks++; if (q_busy[0] !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %0b expected 0", q_busy[0]); end
      checks++; if (q_cyc[0] - s != 609) begin errors++; $display("FAIL basic_latency: got %0d expected 609", q_cyc[0] - s); end
    end
  endtask

  task automatic test_glitch();
    int s;
    clear_q();
    align_start(1'b0, s);
    repeat (12) @(negedge clk);
    rx = 1'b1;
    do begin @(posedge clk); #2; end while (cyc < s + 32);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_before_tick8: got %0b expected 1", busy); end
    @(posedge clk); #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_after_tick8: got %0b expected 0", busy); end
    repeat (80) @(negedge clk);
    checks++; if (q_cyc.size() != 0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", q_cyc.size()); end
    checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL glitch_dout: got %h expected a5", dout); end
  endtask

  task automatic test_framing();
    int s;
    clear_q();
    send_frame(1'b0, 9'h03C, 8, 1'b0, 48, 96, s);
    checks++; if (q_cyc.size() != 1) begin errors++; $display("FAIL ferr_pulses: got %0d expected 1", q_cyc.size()); end
    if (q_cyc.size() > 0) begin
      checks++; if (q_dout[0] !== 8'h3C) begin errors++; $display("FAIL ferr_dout: got %h expected 3c", q_dout[0]); end
      checks++; if (q_ferr[0] !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %0b expected 1", q_ferr[0]); end
    end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_held: got %0b expected 1", frame_err); end
    clear_q();
    send_frame(1'b0, 9'h081, 8, 1'b1, 64, 64, s);
    checks++; if (q_cyc.size() != 1) begin errors++; $display("FAIL clean_pulses: got %0d expected 1", q_cyc.size()); end
    if (q_cyc.size() > 0) begin
      checks++; if (q_dout[0] !== 8'h81) begin errors++; $display("FAIL clean_dout: got %h expected 81", q_dout[0]); end
      checks++; if (q_ferr[0] !== 1'b0) begin errors++; $display("FAIL clean_ferr: got %0b expected 0", q_ferr[0]); end
    end
  endtask

  task automatic test_back_to_back();
    int s1, s2;
    clear_q();
    send_frame(1'b0, 9'h000, 8, 1'b1, 64, 0, s1);
    send_frame(1'b0, 9'h0FF, 8, 1'b1, 64, 64, s2);
    checks++; if (q_cyc.size() != 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", q_cyc.size()); end
    if (q_cyc.size() > 1) begin
      checks++; if (q_dout[0] !== 8'h00) begin errors++; $display("FAIL b2b_dout0: got %h expected 00", q_dout[0]); end
      checks++; if (q_dout[1] !== 8'hFF) begin errors++; $display("FAIL b2b_dout1: got %h expected ff", q_dout[1]); end
      checks++; if (q_cyc[1] - q_cyc[0] != 640) begin errors++; $display("FAIL b2b_spacing: got %0d expected 640", q_cyc[1] - q_cyc[0]); end
      checks++; if ((q_ferr[0] | q_ferr[1]) !== 1'b0) begin errors++; $display("FAIL b2b_ferr: got %0b%0b expected 00", q_ferr[0], q_ferr[1]); end
    end
  endtask

  task automatic test_reset_abort();
    int s;
    logic [7:0] d;
    d = 8'h5A;
    clear_q();
    align_start(1'b0, s);
    repeat (63) @(negedge clk);
    for (int i = 0; i < 4; i++) drive_line(1'b0, d[i], 64);
    drive_line(1'b0, d[4], 32);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    rx = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b expected 0", busy); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL abort_dout: got %h expected 00", dout); end
    repeat (700) @(negedge clk);
    checks++; if (q_cyc.size() != 0) begin errors++; $display("FAIL abort_pulses: got %0d expected 0", q_cyc.size()); end
    send_frame(1'b0, 9'h05A, 8, 1'b1, 64, 64, s);
    checks++; if (q_cyc.size() != 1) begin errors++; $display("FAIL after_abort_pulses: got %0d expected 1", q_cyc.size()); end
    if (q_cyc.size() > 0) begin
      checks++; if (q_dout[0] !== 8'h5A) begin errors++; $display("FAIL after_abort_dout: got %h expected 5a", q_dout[0]); end
      checks++; if (q_cyc[0] - s != 609) begin errors++; $display("FAIL after_abort_latency: got %0d expected 609", q_cyc[0] - s); end
    end
  endtask

  task automatic test_dbit7();
    int s;
    clear_q();
    send_frame(1'b1, 9'h055, 7, 1'b1, 128, 64, s);
    checks++; if (qa_cyc.size() != 1) begin errors++; $display("FAIL d7_sb16_pulses: got %0d expected 1", qa_cyc.size()); end
    checks++; if (qb_cyc.size() != 1) begin errors++; $display("FAIL d7_sb32_pulses: got %0d expected 1", qb_cyc.size()); end
    checks++; if (q_cyc.size() != 0) begin errors++; $display("FAIL d7_main_quiet: got %0d expected 0", q_cyc.size()); end
    if (qa_cyc.size() > 0 && qb_cyc.size() > 0) begin
      checks++; if (qa_dout[0] !== 7'h55) begin errors++; $display("FAIL d7_sb16_dout: got %h expected 55", qa_dout[0]); end
      checks++; if (qb_dout[0] !== 7'h55) begin errors++; $display("FAIL d7_sb32_dout: got %h expected 55", qb_dout[0]); end
      checks++; if (qa_cyc[0] - s != 545) begin errors++; $display("FAIL d7_sb16_latency: got %0d expected 545", qa_cyc[0] - s); end
      checks++; if (qb_cyc[0] - s != 609) begin errors++; $display("FAIL d7_sb32_latency: got %0d expected 609", qb_cyc[0] - s); end
      checks++; if (qb_cyc[0] - qa_cyc[0] != 64) begin errors++; $display("FAIL d7_stop_delta: got %0d expected 64", qb_cyc[0] - qa_cyc[0]); end
    end
    checks++; if (ferr7b !== 1'b0) begin errors++; $display("FAIL d7_sb32_ferr: got %0b expected 0", ferr7b); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_abort();
    test_dbit7();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
